uart_tx: RTL and testbench



---
 rtl/uart_tx_pkg.sv | 40 ++++
 rtl/uart_tx_fifo.sv | 53 +++++
 rtl/uart_tx.sv | 137 +++++++++++++
 tb/tb_uart_tx.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART transmitter: baud select codes, bit periods
// (in clkTx cycles), transmitter state encoding and the baud decode helper.
package uart_tx_pkg;

  // Baud select codes, identical to the ones the receiver decodes.
  localparam logic [1:0] slowest   = 2'd0;
  localparam logic [1:0] kindaSlow = 2'd1;
  localparam logic [1:0] slow      = 2'd2;
  localparam logic [1:0] normal    = 2'd3;

  // Bit periods in clkTx cycles for each baud code.
  localparam int unsigned _1200 = 128;
  localparam int unsigned _2400 = 64;
  localparam int unsigned _4800 = 32;
  localparam int unsigned _9600 = 16;

  // Wide enough to hold the longest bit period itself, not just its last index.
  localparam int unsigned CNT_W = $clog2(_1200 + 1);

  // Transmitter state encoding; names kept distinct from the receiver's.
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Map a baud code to its bit period.
  function automatic logic [CNT_W-1:0] clocks_per_bit(input logic [1:0] code);
    logic [CNT_W-1:0] cpb;
    case (code)
      slowest:   cpb = CNT_W'(_1200);
      kindaSlow: cpb = CNT_W'(_2400);
      slow:      cpb = CNT_W'(_4800);
      default:   cpb = CNT_W'(_9600);
    endcase
    return cpb;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Four-entry byte FIFO feeding the transmitter. The head entry is visible on
// data_o whenever the FIFO is not empty; a pop simply advances past it.
module uart_tx_fifo (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [2:0] count_o
);

  logic [7:0] mem_q [4];
  logic [1:0] wr_ptr_q;
  logic [1:0] rd_ptr_q;
  logic [2:0] count_q;
  logic       do_push;
  logic       do_pop;

  // Requests against a full or empty FIFO are dropped silently.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign full_o  = (count_q == 3'd4);
  assign empty_o = (count_q == 3'd0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; 2-bit pointers wrap 3->0 naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Byte storage; contents are don't-care until written, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: bytes arrive over dataValid/dataReady into a small
// FIFO and are serialised start bit, 8 data bits LSB first, stop bit.
// Handshake: a byte is taken on any clkTx edge where dataValid && dataReady;
// dataValid while dataReady is low is ignored, and dataReady is simply !full.
module uart_tx
  import uart_tx_pkg::*;
(
  input  logic       clkTx,
  input  logic       reset,
  input  logic [1:0] baudRate,
  input  logic [7:0] dataIn,
  input  logic       dataValid,
  output logic       dataReady,
  output logic       serialOutput,
  output logic       busy,
  output logic [2:0] fifoCount,
  output tx_state_e  txState
);

  tx_state_e        state_q;
  logic [CNT_W-1:0] clk_cnt_q;
  logic [CNT_W-1:0] cpb_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             line_q;
  logic             busy_q;

  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  logic [7:0] fifo_head;
  logic [2:0] fifo_count;
  logic       bit_end;

  // Last cycle of the current bit period.
  assign bit_end = (clk_cnt_q == (cpb_q - CNT_W'(1)));

  // A new frame is started from IDLE, or straight out of the last stop cycle.
  assign fifo_pop = !fifo_empty &&
                    ((state_q == TX_IDLE) || ((state_q == TX_STOP) && bit_end));

  uart_tx_fifo u_fifo (
    .clk_i   (clkTx),
    .rst_i   (reset),
    .push_i  (dataValid),
    .pop_i   (fifo_pop),
    .data_i  (dataIn),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign dataReady    = !fifo_full;
  assign fifoCount    = fifo_count;
  assign serialOutput = line_q;
  assign busy         = busy_q;
  assign txState      = state_q;

  // Frame sequencer and serialiser; the line and busy are registered here.
  always_ff @(posedge clkTx or posedge reset) begin
    if (reset) begin
      state_q   <= TX_IDLE;
      clk_cnt_q <= '0;
      cpb_q     <= CNT_W'(_9600);
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      line_q    <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          line_q    <= 1'b1;
          clk_cnt_q <= '0;
          bit_idx_q <= 3'd0;
          if (!fifo_empty) begin
            shift_q <= fifo_head;
            cpb_q   <= clocks_per_bit(baudRate);
            busy_q  <= 1'b1;
            line_q  <= 1'b0;
            state_q <= TX_START;
          end
        end
        TX_START: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            bit_idx_q <= 3'd0;
            line_q    <= shift_q[0];
            state_q   <= TX_DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              line_q  <= 1'b1;
              state_q <= TX_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              line_q    <= shift_q[bit_idx_q + 3'd1];
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            bit_idx_q <= 3'd0;
            if (!fifo_empty) begin
              // Queued byte: go straight into its start bit, no idle gap.
              shift_q <= fifo_head;
              cpb_q   <= clocks_per_bit(baudRate);
              line_q  <= 1'b0;
              state_q <= TX_START;
            end else begin
              line_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= TX_IDLE;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q   <= TX_IDLE;
          clk_cnt_q <= '0;
          line_q    <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed scenarios plus random traffic, every cycle
// compared against a frame-level model of the line, busy flag and queue depth.
module tb_uart_tx;
  import uart_tx_pkg::*;

  logic       clkTx = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] baudRate = normal;
  logic [7:0] dataIn = 8'd0;
  logic       dataValid = 1'b0;
  logic       dataReady;
  logic       serialOutput;
  logic       busy;
  logic [2:0] fifoCount;
  tx_state_e  txState;

  uart_tx dut (
    .clkTx        (clkTx),
    .reset        (reset),
    .baudRate     (baudRate),
    .dataIn       (dataIn),
    .dataValid    (dataValid),
    .dataReady    (dataReady),
    .serialOutput (serialOutput),
    .busy         (busy),
    .fifoCount    (fifoCount),
    .txState      (txState)
  );

  // Clock
  always #5 clkTx = ~clkTx;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: accepted bytes waiting for the line, plus the frame in flight.
  logic [7:0] exp_q[$];
  logic [7:0] m_byte   = 8'd0;
  int         m_start  = 0;
  int         m_cpb    = 1;
  bit         m_active = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int cpb_of(input logic [1:0] code);
    case (code)
      slowest:   return _1200;
      kindaSlow: return _2400;
      slow:      return _4800;
      default:   return _9600;
    endcase
  endfunction

  // Line level k bit-periods into an 8N1 frame carrying b.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_active = 1'b0;
  endtask

  task automatic check_outputs();
    logic exp_line;
    exp_line = m_active ? frame_bit(m_byte, (cyc - m_start) / m_cpb) : 1'b1;
    check("line",  32'(serialOutput), 32'(exp_line));
    check("busy",  32'(busy), 32'(m_active));
    check("count", 32'(fifoCount), 32'(exp_q.size()));
    check("ready", 32'(dataReady), 32'(exp_q.size() < 4));
    check("idle_state", 32'(txState == TX_IDLE), 32'(!m_active));
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    bit acc;
    @(posedge clkTx);
    cyc++;
    if (reset) begin
      model_clear();
    end else begin
      acc = dataValid && (exp_q.size() < 4);
      if (m_active && ((cyc - m_start) >= 10 * m_cpb)) m_active = 1'b0;
      if (!m_active && (exp_q.size() > 0)) begin
        m_byte   = exp_q.pop_front();
        m_start  = cyc;
        m_cpb    = cpb_of(baudRate);
        m_active = 1'b1;
      end
      if (acc) exp_q.push_back(dataIn);
    end
    #1;
    check_outputs();
  endtask

  // Driver
  task automatic push(input logic [7:0] b);
    dataIn    = b;
    dataValid = 1'b1;
    step();
    dataValid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((m_active || (exp_q.size() > 0)) && (n < limit)) begin
      step();
      n++;
    end
    check("idle_timeout", 32'(m_active || (exp_q.size() > 0)), 32'd0);
  endtask

  task automatic wait_bit(input int k, input int limit);
    int n;
    n = 0;
    while (!(m_active && ((cyc - m_start) / m_cpb == k)) && (n < limit)) begin
      step();
      n++;
    end
    check("reach_bit", 32'(m_active && ((cyc - m_start) / m_cpb == k)), 32'd1);
  endtask

  // Independent receiver: find the start bit, then sample mid-bit.
  task automatic rx_byte(input int cpb, input logic [7:0] exp_b);
    logic [7:0] got;
    int n;
    n = 0;
    got = 8'd0;
    while ((serialOutput !== 1'b0) && (n < 3000)) begin
      step();
      n++;
    end
    check("rx_start", 32'(serialOutput), 32'd0);
    repeat (cpb / 2) step();
    check("rx_start_mid", 32'(serialOutput), 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (cpb) step();
      got[i] = serialOutput;
    end
    repeat (cpb) step();
    check("rx_stop", 32'(serialOutput), 32'd1);
    check("rx_data", 32'(got), 32'(exp_b));
  endtask

  // Watchdog
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] r;
    logic [1:0] codes [4];
    codes[0] = normal;
    codes[1] = slow;
    codes[2] = kindaSlow;
    codes[3] = slowest;

    // Reset block
    #2 reset = 1'b1;
    #1;
    check("rst_line",  32'(serialOutput), 32'd1);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_count", 32'(fifoCount), 32'd0);
    check("rst_ready", 32'(dataReady), 32'd1);
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();

    // Single frame 0xA5 at the fastest rate
    baudRate = normal;
    push(8'hA5);
    check("a5_count", 32'(fifoCount), 32'd1);
    rx_byte(_9600, 8'hA5);
    wait_idle(200);
    repeat (5) step();

    // Three consecutive pushes, frames back to back
    push(8'h00);
    check("t2_ready0", 32'(dataReady), 32'd1);
    push(8'hFF);
    check("t2_ready1", 32'(dataReady), 32'd1);
    push(8'h3C);
    check("t2_ready2", 32'(dataReady), 32'd1);
    wait_idle(1000);
    repeat (3) step();

    // Five pushes fill the FIFO behind the frame in flight; a sixth is dropped
    for (int i = 0; i < 5; i++) push(8'($urandom));
    check("full_count", 32'(fifoCount), 32'd4);
    check("full_ready", 32'(dataReady), 32'd0);
    push(8'($urandom));
    check("full_count_after", 32'(fifoCount), 32'd4);
    wait_idle(2000);
    repeat (3) step();

    // Baud change during frame 1 data bits only affects frame 2
    baudRate = normal;
    push(8'($urandom));
    push(8'($urandom));
    wait_bit(3, 200);
    baudRate = slowest;
    wait_idle(4000);
    repeat (3) step();

    // Asynchronous reset during data bit 3 (bit 3 forced low so the line change is visible)
    baudRate = normal;
    r = 8'($urandom) & 8'hF7;
    push(r);
    push(8'($urandom));
    wait_bit(4, 200);
    #3 reset = 1'b1;
    #1;
    check("arst_line",  32'(serialOutput), 32'd1);
    check("arst_busy",  32'(busy), 32'd0);
    check("arst_count", 32'(fifoCount), 32'd0);
    check("arst_ready", 32'(dataReady), 32'd1);
    model_clear();
    repeat (2) step();
    reset = 1'b0;
    step();
    push(8'h81);
    rx_byte(_9600, 8'h81);
    wait_idle(200);

    // Loopback-style decode at every baud code
    for (int c = 0; c < 4; c++) begin
      baudRate = codes[c];
      push(8'h55);
      rx_byte(cpb_of(codes[c]), 8'h55);
      wait_idle(3000);
      push(8'hAA);
      rx_byte(cpb_of(codes[c]), 8'hAA);
      wait_idle(3000);
    end

    // Random traffic with random baud codes and valid pulses
    for (int i = 0; i < 400; i++) begin
      baudRate  = 2'($urandom_range(2, 3));
      dataIn    = 8'($urandom);
      dataValid = 1'($urandom_range(0, 1));
      step();
    end
    dataValid = 1'b0;
    wait_idle(4000);
    repeat (5) step();

    // Report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
